fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the fetch PC and drives a request/response instruction-memory port with at most one outstanding request. It presents one fetched instruction at a time, with PCF and PCPlus4F, to the IF/ID pipeline register. It handles hazard-unit stalls and execute-stage branch/jump redirects, and discards any in-flight fetch made stale by a redirect.

---
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues one outstanding imem request at a time,
// holds the fetched word for IF/ID and discards responses made stale by an execute-stage redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] npc, npc_nxt, npc_plus4;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] pcf_q, pcf_nxt;
  logic [31:0] pcp4_q, pcp4_nxt;
  logic        buf_valid, buf_valid_nxt;
  logic        kill, kill_nxt;
  logic        accept, capture;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign npc_plus4   = npc + 32'd4;
  assign imem_addr   = npc;
  assign instruction = buf_valid ? instr_q : NOP_INSTR;
  assign PCF         = pcf_q;
  assign PCPlus4F    = pcp4_q;
  assign FetchBusy   = !buf_valid;

  always_comb begin
    state_nxt     = state;
    npc_nxt       = npc;
    buf_valid_nxt = buf_valid;
    kill_nxt      = kill;
    instr_nxt     = instr_q;
    pcf_nxt       = pcf_q;
    pcp4_nxt      = pcp4_q;
    capture       = 1'b0;
    // Only request when the buffer is empty or drains this edge, so a response never meets a full buffer.
    imem_req      = (state == S_REQ) && (!buf_valid || !StallF);
    accept        = imem_req && imem_ready;

    if (buf_valid && !StallF)
      buf_valid_nxt = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (accept) begin
          state_nxt = S_WAIT;
          kill_nxt  = PCSrcE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = S_REQ;
          kill_nxt  = 1'b0;
          capture   = !kill && !PCSrcE;
        end else if (PCSrcE) begin
          kill_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (capture) begin
      instr_nxt     = imem_rdata;
      pcf_nxt       = npc;
      pcp4_nxt      = npc_plus4;
      npc_nxt       = npc_plus4;
      buf_valid_nxt = 1'b1;
    end

    // Redirect wins over stall and over capture.
    if (PCSrcE) begin
      npc_nxt       = align_word(PCTargetE);
      buf_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      npc       <= RESET_PC;
      buf_valid <= 1'b0;
      kill      <= 1'b0;
      pcf_q     <= 32'd0;
      pcp4_q    <= 32'd0;
    end else begin
      state     <= state_nxt;
      npc       <= npc_nxt;
      buf_valid <= buf_valid_nxt;
      kill      <= kill_nxt;
      pcf_q     <= pcf_nxt;
      pcp4_q    <= pcp4_nxt;
    end
  end

  // Instruction word is masked by buf_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    instr_q <= instr_nxt;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level memory/program-flow model feeds a scoreboard
// queue of expected {PC, instruction} pairs; a separate monitor checks what the stage presents.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          NCYC     = 6000;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FetchBusy;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instruction(instruction),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .FetchBusy(FetchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     n_accept = 0;
  int     n_present = 0;
  logic   rst_edge = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whether the edge just taken applied reset.
  always @(posedge clk) rst_edge <= rst;

  // Stimulus + memory + program-flow model
  initial begin
    bit          pend;
    bit          pend_stale;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;
    int          pend_cnt;
    logic [31:0] exp_next;
    entry_t      e;

    rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    pend = 1'b0; pend_stale = 1'b0; pend_addr = 32'd0; pend_data = 32'd0; pend_cnt = 0;
    exp_next = RESET_PC;
    repeat (3) @(posedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      rst = (cyc > 20) && ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) StallF = ($urandom_range(0, 2) == 0);
      PCSrcE = !rst && ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0: PCTargetE = 32'h0000_0100;
        1: PCTargetE = 32'h0000_0103;
        2: PCTargetE = 32'hFFFF_FFFC;
        3: PCTargetE = 32'hFFFF_FFF6;
        default: PCTargetE = $urandom;
      endcase
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_data;
        end
      end
      imem_ready = !pend && ($urandom_range(0, 3) != 0);
      #2;
      // What the coming edge does, seen from the memory and program flow.
      if (imem_req) check32("imem_addr", imem_addr, exp_next);
      if (imem_rvalid) begin
        if (!(pend_stale || PCSrcE || rst)) begin
          e.pc    = pend_addr;
          e.instr = pend_data;
          exp_q.push_back(e);
          exp_next = pend_addr + 32'd4;
        end
        pend = 1'b0;
      end
      if (imem_req && imem_ready) begin
        pend       = 1'b1;
        pend_stale = PCSrcE || rst;
        pend_addr  = imem_addr;
        pend_data  = $urandom;
        pend_cnt   = $urandom_range(1, 3);
        n_accept++;
      end else if (pend && (PCSrcE || rst)) begin
        pend_stale = 1'b1;
      end
      if (rst)
        exp_next = RESET_PC;
      else if (PCSrcE)
        exp_next = {PCTargetE[31:2], 2'b00};
    end

    @(posedge clk);
    #1;
    rst = 1'b0; PCSrcE = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (n_accept < 200) begin
      n_err++;
      $display("FAIL accept_progress: got %0d accepts required at least 200", n_accept);
    end
    n_cmp++;
    if (n_present < 100) begin
      n_err++;
      $display("FAIL present_progress: got %0d instructions required at least 100", n_present);
    end
    n_cmp++;
    if (exp_q.size() > 1) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries required at most 1", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Monitor: checks the presented instruction against the scoreboard
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        check32("rst_busy", {31'd0, FetchBusy}, 32'd1);
        check32("rst_instr", instruction, NOP);
        check32("rst_pcf", PCF, 32'd0);
        check32("rst_pcplus4", PCPlus4F, 32'd0);
        check32("rst_req", {31'd0, imem_req}, 32'd0);
      end
      if (FetchBusy) begin
        check32("nop_when_empty", instruction, NOP);
      end else begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_instr: got pc %h instr %h required no valid instruction at %0t",
                   PCF, instruction, $time);
        end else begin
          e = exp_q[0];
          check32("instruction", instruction, e.instr);
          check32("pcf", PCF, e.pc);
          check32("pcplus4", PCPlus4F, e.pc + 32'd4);
          if (StallF) check32("req_while_stalled", {31'd0, imem_req}, 32'd0);
          if (!StallF || PCSrcE || rst) begin
            void'(exp_q.pop_front());
            n_present++;
          end
        end
      end
    end
  end

endmodule
